// File: rtl/weight_fetch_if.sv
// Weight-fetch bus: tile-side start/pop handshake, FIFO-head outputs and the
// weight-memory read port, bundled so the fetcher sees one port.
interface weight_fetch_if #(
    parameter int NUM_NEURONS = 128,
    parameter int ADDR_W      = 10
);
    logic                   start;
    logic                   get_weights;
    logic [NUM_NEURONS-1:0] weights;
    logic                   weights_valid;
    logic                   layer;
    logic                   last;
    logic                   busy;
    logic                   underflow;
    logic                   mem_rd;
    logic [ADDR_W-1:0]      mem_addr;
    logic [NUM_NEURONS-1:0] mem_rdata;

    // Fetcher side
    modport slave (
        input  start, get_weights, mem_rdata,
        output weights, weights_valid, layer, last, busy, underflow,
               mem_rd, mem_addr
    );

    // Tile + memory side
    modport master (
        output start, get_weights, mem_rdata,
        input  weights, weights_valid, layer, last, busy, underflow,
               mem_rd, mem_addr
    );
endinterface

// File: rtl/weight_fetch.sv
// Weight prefetcher: streams the binarized weight memory (layer-0 words, then
// layer-1 words) through a small FIFO that hides the fixed memory latency.
// Each word carries a layer tag and a last-of-image flag.
module weight_fetch #(
    parameter int NUM_NEURONS = 128,
    parameter int IMG_SZ      = 784,
    parameter int OUTPUT_SZ   = 10,
    parameter int MEM_LAT     = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    weight_fetch_if.slave bus
);

    localparam int TOTAL = IMG_SZ + NUM_NEURONS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] IMG_ADDR  = ADDR_W'(IMG_SZ);
    localparam bit PARAMS_OK = (OUTPUT_SZ <= NUM_NEURONS) && (MEM_LAT >= 1) &&
                               (FIFO_DEPTH >= MEM_LAT + 1) &&
                               ((1 << ADDR_W) >= TOTAL);

    // Refuse to elaborate with a parameter set the datapath cannot support
    if (!PARAMS_OK) begin : g_param_check
        $error("weight_fetch: inconsistent parameters");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      issue_ptr_q, issue_ptr_d;
    logic [MEM_LAT-1:0]     vld_q, vld_d;
    logic [MEM_LAT-1:0]     lay_pipe_q, lay_pipe_d;
    logic [MEM_LAT-1:0]     lst_pipe_q, lst_pipe_d;
    logic [NUM_NEURONS-1:0] data_fifo_q [FIFO_DEPTH];
    logic [NUM_NEURONS-1:0] data_fifo_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  lay_fifo_q, lay_fifo_d;
    logic [FIFO_DEPTH-1:0]  lst_fifo_q, lst_fifo_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   underflow_q, underflow_d;

    logic [CNT_W-1:0]       inflight;
    logic [OCC_W-1:0]       occ;
    logic                   head_valid;
    logic                   issue;
    logic                   push;
    logic                   pop;

    // Handshake decisions, all derived from registered state plus inputs
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
        end
        occ        = OCC_W'(count_q) + OCC_W'(inflight);
        head_valid = (count_q != '0);
        // Reserving a slot per in-flight read means a return can never overflow
        issue      = (state_q == S_FETCH) && (occ < OCC_W'(FIFO_DEPTH));
        // A restart discards the returning word and ignores any pop
        pop        = bus.get_weights && head_valid && !bus.start;
        push       = vld_q[MEM_LAT-1] && !bus.start;
    end

    // Next-state for the FSM, read pipeline and FIFO
    always_comb begin
        state_d     = state_q;
        issue_ptr_d = issue_ptr_q;
        data_fifo_d = data_fifo_q;
        lay_fifo_d  = lay_fifo_q;
        lst_fifo_d  = lst_fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;

        // Tags travel alongside the read so the FIFO never decodes addresses
        vld_d[0]      = issue;
        lay_pipe_d[0] = (issue_ptr_q >= IMG_ADDR);
        lst_pipe_d[0] = (issue_ptr_q == LAST_ADDR);
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i]      = vld_q[i-1];
            lay_pipe_d[i] = lay_pipe_q[i-1];
            lst_pipe_d[i] = lst_pipe_q[i-1];
        end

        if (push) begin
            data_fifo_d[wr_ptr_q] = bus.mem_rdata;
            lay_fifo_d[wr_ptr_q]  = lay_pipe_q[MEM_LAT-1];
            lst_fifo_d[wr_ptr_q]  = lst_pipe_q[MEM_LAT-1];
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.get_weights && !head_valid) begin
            underflow_d = 1'b1;
        end

        case (state_q)
            S_FETCH: begin
                if (issue) begin
                    issue_ptr_d = issue_ptr_q + ADDR_W'(1);
                    if (issue_ptr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && lst_fifo_q[rd_ptr_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // Start (or restart) overrides everything: flush and rewind
        if (bus.start) begin
            state_d     = S_FETCH;
            issue_ptr_d = '0;
            vld_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            issue_ptr_q <= '0;
            vld_q       <= '0;
            lay_pipe_q  <= '0;
            lst_pipe_q  <= '0;
            lay_fifo_q  <= '0;
            lst_fifo_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_ptr_q <= issue_ptr_d;
            vld_q       <= vld_d;
            lay_pipe_q  <= lay_pipe_d;
            lst_pipe_q  <= lst_pipe_d;
            lay_fifo_q  <= lay_fifo_d;
            lst_fifo_q  <= lst_fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO data entries; cleared on reset so the head word reads 0 out of reset
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_fifo_q[gi] <= '0;
            end else begin
                data_fifo_q[gi] <= data_fifo_d[gi];
            end
        end
    end

    assign bus.weights       = data_fifo_q[rd_ptr_q];
    assign bus.weights_valid = head_valid;
    assign bus.layer         = head_valid && lay_fifo_q[rd_ptr_q];
    assign bus.last          = head_valid && lst_fifo_q[rd_ptr_q];
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.underflow     = underflow_q;
    assign bus.mem_rd        = issue;
    assign bus.mem_addr      = issue_ptr_q;

endmodule

// File: tb/tb_weight_fetch.sv
// Bench for weight_fetch: fixed-latency memory model returning word k = {k,k},
// expected words queued at each start, a negedge monitor that checks every pop
// and every read issue, plus directed timing/boundary checks.
module tb_weight_fetch;
    localparam int NN    = 128;
    localparam int IMG   = 784;
    localparam int OSZ   = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int TOTAL = 912;

    typedef struct packed {
        logic [NN-1:0] data;
        logic          layer;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weight_fetch_if #(.NUM_NEURONS(NN), .ADDR_W(AW)) wf_if ();

    weight_fetch #(
        .NUM_NEURONS(NN), .IMG_SZ(IMG), .OUTPUT_SZ(OSZ),
        .MEM_LAT(LAT), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wf_if)
    );

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   pass_pops = 0;
    int   issued    = 0;
    int   exp_addr  = 0;

    function automatic logic [NN-1:0] mem_word(input int k);
        return {64'(k), 64'(k)};
    endfunction

    // Weight memory: data appears LAT cycles after the read strobe
    logic          mv [LAT];
    logic [AW-1:0] ma [LAT];
    always @(posedge clk) begin
        mv[0] <= wf_if.mem_rd;
        ma[0] <= wf_if.mem_addr;
        for (int i = 1; i < LAT; i++) begin
            mv[i] <= mv[i-1];
            ma[i] <= ma[i-1];
        end
    end
    assign wf_if.mem_rdata = mv[LAT-1] ? mem_word(int'(ma[LAT-1])) : {4{32'hBAD0_BAD0}};

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: checks read ordering/occupancy and every popped word
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || wf_if.start) begin
                pass_pops = 0;
                issued    = 0;
                exp_addr  = 0;
            end else begin
                if (wf_if.mem_rd) begin
                    chk("rd_addr", 160'(wf_if.mem_addr), 160'(exp_addr));
                    checks++;
                    if (issued - pass_pops >= DEPTH) begin
                        errors++;
                        $display("FAIL occupancy: issue with %0d outstanding, limit %0d",
                                 issued - pass_pops, DEPTH);
                    end
                    exp_addr++;
                    issued++;
                end
                if (wf_if.get_weights && wf_if.weights_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got %0h with no word expected", wf_if.weights);
                    end else begin
                        e = exp_q.pop_front();
                        if ({wf_if.weights, wf_if.layer, wf_if.last} !== e) begin
                            errors++;
                            $display("FAIL pop_word #%0d: got data %0h layer %0b last %0b expected data %0h layer %0b last %0b",
                                     pass_pops, wf_if.weights, wf_if.layer, wf_if.last,
                                     e.data, e.layer, e.last);
                        end
                    end
                    pass_pops++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the whole expected pass, then pulse start for one cycle
    task automatic do_start();
        exp_q.delete();
        for (int k = 0; k < TOTAL; k++) begin
            exp_q.push_back('{data: mem_word(k), layer: (k >= IMG), last: (k == TOTAL - 1)});
        end
        wf_if.start = 1'b1;
        tick();
        wf_if.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (!wf_if.busy) break;
            if (cyc >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s: still busy after %0d cycles, required idle", name, cyc);
                break;
            end
        end
    endtask

    function automatic logic [159:0] all_outputs();
        return 160'({wf_if.weights, wf_if.mem_addr, wf_if.weights_valid, wf_if.layer,
                     wf_if.last, wf_if.busy, wf_if.underflow, wf_if.mem_rd});
    endfunction

    initial begin
        int c;
        int rd;
        wf_if.start       = 1'b0;
        wf_if.get_weights = 1'b0;

        // Reset state
        #2;
        chk("reset_outputs", all_outputs(), 160'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Basic pass: latency, no bubbles, tags, busy fall
        do_start();
        @(negedge clk);
        chk("t1_rd_cycle1", 160'({wf_if.mem_rd, wf_if.mem_addr}), 160'({1'b1, 10'd0}));
        @(negedge clk);
        @(negedge clk);
        chk("t1_valid_cycle3", 160'(wf_if.weights_valid), 160'(0));
        @(negedge clk);
        chk("t1_valid_cycle4", 160'(wf_if.weights_valid), 160'(1));
        chk("t1_head_word0", 160'(wf_if.weights), 160'(0));
        tick();
        wf_if.get_weights = 1'b1;
        c = 4;
        while (1) begin
            @(negedge clk);
            c++;
            if (!wf_if.busy) break;
            if (c > 3000) begin
                checks++;
                errors++;
                $display("FAIL t1_timeout: busy at cycle %0d, required idle by 917", c);
                break;
            end
        end
        chk("t1_busy_fall_cycle", 160'(c), 160'(917));
        chk("t1_pops", 160'(pass_pops), 160'(TOTAL));
        chk("t1_underflow", 160'(wf_if.underflow), 160'(0));
        chk("t1_valid_after", 160'(wf_if.weights_valid), 160'(0));
        tick();
        wf_if.get_weights = 1'b0;

        // Back-pressure: exactly DEPTH reads, FIFO full holding word 0
        do_start();
        rd = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            rd += int'(wf_if.mem_rd);
        end
        chk("t2_reads", 160'(rd), 160'(4));
        chk("t2_rd_stopped", 160'(wf_if.mem_rd), 160'(0));
        chk("t2_valid", 160'(wf_if.weights_valid), 160'(1));
        chk("t2_head_word0", 160'({wf_if.weights, wf_if.layer, wf_if.last}), 160'(0));

        // Random 30% pops for the rest of the pass
        c = 0;
        while (1) begin
            tick();
            wf_if.get_weights = ($urandom_range(0, 99) < 30);
            @(negedge clk);
            c++;
            if (!wf_if.busy) break;
            if (c > 8000) begin
                checks++;
                errors++;
                $display("FAIL t3_timeout: busy after %0d cycles, required idle", c);
                break;
            end
        end
        chk("t3_pops", 160'(pass_pops), 160'(TOTAL));
        tick();
        wf_if.get_weights = 1'b0;

        // Underflow: pop attempt in cycle 2, sticky, no word consumed
        do_start();
        tick();
        wf_if.get_weights = 1'b1;
        tick();
        wf_if.get_weights = 1'b0;
        @(negedge clk);
        chk("t4_underflow_set", 160'(wf_if.underflow), 160'(1));
        repeat (5) @(negedge clk);
        chk("t4_underflow_sticky", 160'(wf_if.underflow), 160'(1));
        chk("t4_no_pop", 160'(pass_pops), 160'(0));
        chk("t4_valid_full", 160'(wf_if.weights_valid), 160'(1));

        // Restart mid-pass at word 100; next word must be 0 again
        tick();
        wf_if.get_weights = 1'b1;
        c = 0;
        while (pass_pops < 100) begin
            tick();
            c++;
            if (c > 500) begin
                checks++;
                errors++;
                $display("FAIL t5_timeout: %0d pops, required 100", pass_pops);
                break;
            end
        end
        do_start();
        @(negedge clk);
        chk("t5_underflow_cleared", 160'(wf_if.underflow), 160'(0));
        wait_idle("t5_idle", 3000);
        chk("t5_pops", 160'(pass_pops), 160'(TOTAL));
        tick();
        wf_if.get_weights = 1'b0;

        // Async reset mid-FETCH, then a clean pass
        wf_if.get_weights = 1'b1;
        do_start();
        repeat (10) tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_reset_outputs", all_outputs(), 160'(0));
        wf_if.get_weights = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("t6_idle_after_release", all_outputs(), 160'(0));
        tick();
        wf_if.get_weights = 1'b1;
        do_start();
        wait_idle("t6_idle", 3000);
        chk("t6_pops", 160'(pass_pops), 160'(TOTAL));
        tick();
        wf_if.get_weights = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_fetch.md
# weight_fetch

Upstream feeder for the neural-network tile. On `start` it walks the binarized weight memory from word 0 upward and keeps a small prefetch FIFO full, hiding the memory read latency. The tile pulls one weight word per `get_weights` pulse: first the IMG_SZ layer-0 words, then the NUM_NEURONS layer-1 words. The block tags each word with its layer and flags the final word of the image pass.

## Interface
- NUM_NEURONS, 128, weight word width; one bit per layer-0 neuron.
- IMG_SZ, 784, number of layer-0 words (one per pixel).
- OUTPUT_SZ, 10, layer-1 neuron count; layer-1 words use bits [OUTPUT_SZ-1:0], upper bits forwarded untouched.
- MEM_LAT, 2, fixed read latency of the weight memory in cycles (≥1).
- FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, ≥ MEM_LAT+1).
- ADDR_W, 10, memory address width; must satisfy 2^ADDR_W ≥ IMG_SZ+NUM_NEURONS.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins (or restarts) a pass at address 0.
- get_weights  in  1  tile pops the head word this cycle.
- weights  out  NUM_NEURONS  FIFO head word; valid only when weights_valid=1.
- weights_valid  out  1  FIFO non-empty.
- layer  out  1  0 = head is a layer-0 word, 1 = layer-1 word.
- last  out  1  head is word IMG_SZ+NUM_NEURONS-1.
- busy  out  1  pass in progress (state ≠ IDLE).
- underflow  out  1  sticky: get_weights seen while weights_valid=0; cleared by start or reset.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  NUM_NEURONS  read data; valid exactly MEM_LAT cycles after the mem_rd cycle.

## Operation
- TOTAL = IMG_SZ + NUM_NEURONS (912 at defaults). Word index k < IMG_SZ → layer 0, else layer 1.
- States: IDLE, FETCH, DRAIN.
  - IDLE: no reads. Start → FETCH.
  - FETCH: issue reads. Once the read of word TOTAL-1 is issued → DRAIN.
  - DRAIN: no new reads. After the pop of the `last` word → IDLE.
- Issue rule: mem_rd=1 in FETCH iff (fifo_count + inflight) < FIFO_DEPTH. mem_addr = issue pointer, which increments on each issue.
- Inflight tracking: MEM_LAT-deep valid shift register; each returning word is pushed into the FIFO together with its layer and last tags.
- Pop: get_weights with weights_valid=1 pops the head. Push and pop in the same cycle leave the count unchanged.
- get_weights with weights_valid=0: no pop, underflow←1.
- start while busy (restart): flush the FIFO, zero the issue pointer, and mark all inflight returns as discard (never pushed). Clear underflow. Go to FETCH.
- start in the same cycle as get_weights: start wins; the pop is ignored.
- Reset values: every output 0, including mem_addr and weights. State is IDLE, pointers and counts 0, shift register cleared. Reset mid-pass abandons all inflight data.

## Timing
- Start is sampled at edge E0. mem_rd=1 with addr 0 in the cycle after E0 (cycle 1).
- Data is pushed at the edge ending cycle 1+MEM_LAT. weights_valid=1 in cycle 2+MEM_LAT (cycle 4 at defaults).
- Steady state with get_weights held high: one word per cycle, no bubbles.
- weights, layer and last are registered FIFO-head outputs with no combinational path from get_weights. mem_rd is a registered-state function only.
- busy falls the cycle after the `last` pop.
- Words are delivered strictly in order; no address is skipped or repeated within a pass.

## Test plan
- Basic pass, defaults, memory word k = k, get_weights held high:
  - 912 words popped in order, first valid at cycle 4.
  - layer rises on word 784; last is high only on word 911.
  - busy low after it; underflow=0.
- Back-pressure, get_weights low for 20 cycles after start:
  - exactly 4 reads issued (addr 0–3), then mem_rd stays 0.
  - FIFO full; weights=0 word held stable.
- Random get_weights, 30% duty, full pass: scoreboard shows 912 in-order words, no duplicates, inflight+count never exceeds 4.
- Underflow: get_weights pulsed in cycle 2 after start → underflow=1 and sticky, no pop. The next start clears it.
- Restart mid-pass: start at word 100 while 2 reads are in flight → the next delivered word is 0, and stale words 100+ never appear.
- Async reset asserted mid-FETCH → all outputs 0 immediately; after release, idle until start, then a normal pass succeeds.
